hdmi_scanout_ctl: RTL and testbench

Line-fetch sequencer that feeds the HDMI pixel pipeline from a framebuffer in DRAM. It issues read bursts against a simple address/data memory read port, one scanline per `i_line_req`, and writes the returned pixels into a double-banked line buffer that the HDMI core scans out. Configuration (base, stride, width, height) comes from the AXI register block and is shadowed at each frame start. Both the AXI side and the pixel side are in the same clock domain here; any CDC lives outside this block.

---
 rtl/scanout_pkg.sv | 23 ++
 rtl/hdmi_scanout_ctl.sv | 182 ++++++++++++++++++
 tb/tb_hdmi_scanout_ctl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scanout_pkg.sv
// Shared definitions for the HDMI scanout line-fetch sequencer.
//   - scan_state_e    : sequencer state encoding (IDLE/ADDR/DATA/DRAIN)
//   - BYTES_PER_PIXEL : one XRGB pixel per data beat, 4 bytes each
//   - burst_len()     : beats-minus-one for the next burst, min(burst, remaining) - 1
package scanout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } scan_state_e;

    localparam int BYTES_PER_PIXEL = 4;

    // Caller guarantees remaining != 0; burst is at most 256, so 8 bits suffice.
    function automatic logic [7:0] burst_len(input int unsigned burst,
                                             input logic [15:0]  remaining);
        if (remaining >= 16'(burst)) return 8'(burst - 1);
        return 8'(remaining - 16'd1);
    endfunction

endpackage

// File: rtl/hdmi_scanout_ctl.sv
// Line-fetch sequencer: reads one scanline per i_line_req from a framebuffer
// in DRAM as bursts on a simple address/data read port, and writes the pixels
// into a double-banked line buffer for the HDMI scanout core.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_enable, i_frame_start    arm/disarm fetching; shadow config on frame start
//   i_base/stride/width/height frame configuration from the register block
//   i_line_req                 fetch next line (dropped and counted while busy)
//   o_rd_valid/addr/len, i_rd_ready   burst address handshake
//   i_rdata_valid, i_rdata     returned beats, no backpressure
//   o_lb_we/addr/wdata/bank    line-buffer write port
//   o_line_done, o_busy, o_overrun_cnt   status
module hdmi_scanout_ctl
    import scanout_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int BURST  = 16,
    parameter int XBITS  = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_enable,
    input  logic [AWIDTH-1:0]        i_base,
    input  logic [15:0]              i_stride,
    input  logic [XBITS-1:0]         i_width,
    input  logic [XBITS-1:0]         i_height,
    input  logic                     i_frame_start,
    input  logic                     i_line_req,
    output logic                     o_rd_valid,
    output logic [AWIDTH-1:0]        o_rd_addr,
    output logic [$clog2(BURST)-1:0] o_rd_len,
    input  logic                     i_rd_ready,
    input  logic                     i_rdata_valid,
    input  logic [DWIDTH-1:0]        i_rdata,
    output logic                     o_lb_we,
    output logic [XBITS-1:0]         o_lb_addr,
    output logic [DWIDTH-1:0]        o_lb_wdata,
    output logic                     o_lb_bank,
    output logic                     o_line_done,
    output logic                     o_busy,
    output logic [15:0]              o_overrun_cnt
);

    localparam int                LENW        = $clog2(BURST);
    localparam logic [AWIDTH-1:0] BURST_BYTES = AWIDTH'(BURST * BYTES_PER_PIXEL);

    scan_state_e       state, state_next;
    logic              armed;
    logic              drain_pend;     // frame restarted while address was pending
    logic [15:0]       sh_stride;
    logic [XBITS-1:0]  sh_width, sh_height;
    logic [XBITS-1:0]  line_cnt;
    logic [AWIDTH-1:0] line_addr;
    logic [XBITS-1:0]  remaining;      // pixels not yet requested for this line
    logic [XBITS-1:0]  beat_idx;
    logic [LENW-1:0]   burst_cnt;

    // Config as seen this cycle: a coincident frame start is applied before the
    // line request is evaluated.
    logic              armed_v;
    logic [XBITS-1:0]  width_v, height_v, line_v;
    logic [AWIDTH-1:0] base_aligned, laddr_v;
    logic              start_ok, beat_last;

    assign base_aligned = i_base & ~AWIDTH'(3);
    assign armed_v      = i_frame_start ? i_enable     : armed;
    assign width_v      = i_frame_start ? i_width      : sh_width;
    assign height_v     = i_frame_start ? i_height     : sh_height;
    assign line_v       = i_frame_start ? '0           : line_cnt;
    assign laddr_v      = i_frame_start ? base_aligned : line_addr;

    assign start_ok  = (state == IDLE) && i_line_req && armed_v &&
                       (line_v < height_v) && (width_v != '0);
    assign beat_last = i_rdata_valid && (burst_cnt == o_rd_len);

    assign o_rd_valid = (state == ADDR);
    assign o_busy     = (state != IDLE);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start_ok) state_next = ADDR;
            ADDR:  if (i_rd_ready)
                       state_next = (drain_pend || i_frame_start) ? DRAIN : DATA;
            DATA:  if (i_frame_start)
                       state_next = beat_last ? IDLE : DRAIN;
                   else if (beat_last)
                       state_next = (remaining != '0) ? ADDR : IDLE;
            DRAIN: if (beat_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous; there is no storage array here, so
        // every register is cleared.
        if (!rst_n) begin
            state         <= IDLE;
            armed         <= 1'b0;
            drain_pend    <= 1'b0;
            sh_stride     <= '0;
            sh_width      <= '0;
            sh_height     <= '0;
            line_cnt      <= '0;
            line_addr     <= '0;
            remaining     <= '0;
            beat_idx      <= '0;
            burst_cnt     <= '0;
            o_rd_addr     <= '0;
            o_rd_len      <= '0;
            o_lb_we       <= 1'b0;
            o_lb_addr     <= '0;
            o_lb_wdata    <= '0;
            o_lb_bank     <= 1'b0;
            o_line_done   <= 1'b0;
            o_overrun_cnt <= '0;
        end else begin
            state       <= state_next;
            o_lb_we     <= 1'b0;
            o_line_done <= 1'b0;

            // The bank flips the cycle after the final write of a line.
            if (o_line_done) o_lb_bank <= ~o_lb_bank;

            if (i_frame_start) begin
                armed     <= i_enable;
                sh_stride <= i_stride & 16'hFFFC;
                sh_width  <= i_width;
                sh_height <= i_height;
                line_cnt  <= '0;
                line_addr <= base_aligned;
                o_lb_bank <= 1'b0;
            end

            if (i_line_req && (state != IDLE) && (o_overrun_cnt != 16'hFFFF))
                o_overrun_cnt <= o_overrun_cnt + 16'd1;

            unique case (state)
                IDLE: if (start_ok) begin
                    o_rd_addr  <= laddr_v;
                    o_rd_len   <= LENW'(burst_len(BURST, 16'(width_v)));
                    remaining  <= width_v;
                    beat_idx   <= '0;
                    drain_pend <= 1'b0;
                end
                ADDR: begin
                    if (i_frame_start) drain_pend <= 1'b1;
                    if (i_rd_ready) begin
                        remaining <= remaining - (XBITS'(o_rd_len) + XBITS'(1));
                        burst_cnt <= '0;
                    end
                end
                DATA: if (i_rdata_valid) begin
                    burst_cnt <= burst_cnt + LENW'(1);
                    beat_idx  <= beat_idx + XBITS'(1);
                    // A frame restart drops the coincident beat along with the rest.
                    if (!i_frame_start) begin
                        o_lb_we    <= 1'b1;
                        o_lb_addr  <= beat_idx;
                        o_lb_wdata <= i_rdata;
                        if (beat_last && (remaining == '0)) begin
                            o_line_done <= 1'b1;
                            line_cnt    <= line_cnt + XBITS'(1);
                            line_addr   <= line_addr + AWIDTH'(sh_stride);
                        end else if (beat_last) begin
                            o_rd_addr <= o_rd_addr + BURST_BYTES;
                            o_rd_len  <= LENW'(burst_len(BURST, 16'(remaining)));
                        end
                    end
                end
                DRAIN: if (i_rdata_valid) burst_cnt <= burst_cnt + LENW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_scanout_ctl.sv
// Scoreboard bench for hdmi_scanout_ctl: stimulus pushes hand-computed bursts
// and line-buffer writes into queues; a monitor pops and compares them as the
// DUT presents address handshakes and write strobes. A responder process plays
// the memory, returning beat data equal to the beat's byte address.
module tb_hdmi_scanout_ctl;

    localparam int AWIDTH = 32;
    localparam int DWIDTH = 32;
    localparam int BURST  = 16;
    localparam int XBITS  = 11;
    localparam int LENW   = $clog2(BURST);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_enable = 1'b0;
    logic [AWIDTH-1:0] i_base = '0;
    logic [15:0]       i_stride = '0;
    logic [XBITS-1:0]  i_width = '0;
    logic [XBITS-1:0]  i_height = '0;
    logic              i_frame_start = 1'b0;
    logic              i_line_req = 1'b0;
    logic              o_rd_valid;
    logic [AWIDTH-1:0] o_rd_addr;
    logic [LENW-1:0]   o_rd_len;
    logic              i_rd_ready = 1'b0;
    logic              i_rdata_valid = 1'b0;
    logic [DWIDTH-1:0] i_rdata = '0;
    logic              o_lb_we;
    logic [XBITS-1:0]  o_lb_addr;
    logic [DWIDTH-1:0] o_lb_wdata;
    logic              o_lb_bank;
    logic              o_line_done;
    logic              o_busy;
    logic [15:0]       o_overrun_cnt;

    always #5 clk = ~clk;

    hdmi_scanout_ctl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .BURST(BURST), .XBITS(XBITS)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_base(i_base),
        .i_stride(i_stride), .i_width(i_width), .i_height(i_height),
        .i_frame_start(i_frame_start), .i_line_req(i_line_req),
        .o_rd_valid(o_rd_valid), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
        .i_rd_ready(i_rd_ready), .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata),
        .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_wdata(o_lb_wdata),
        .o_lb_bank(o_lb_bank), .o_line_done(o_line_done), .o_busy(o_busy),
        .o_overrun_cnt(o_overrun_cnt)
    );

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [LENW-1:0]   len;
    } burst_t;

    typedef struct {
        logic [XBITS-1:0]  idx;
        logic [DWIDTH-1:0] data;
        logic              bank;
        logic              done;
    } wr_t;

    burst_t exp_burst[$];
    wr_t    exp_wr[$];
    int     checks = 0;
    int     failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input logic [AWIDTH-1:0] addr, input int len);
        burst_t b;
        b.addr = addr;
        b.len  = LENW'(len);
        exp_burst.push_back(b);
    endtask

    // Writes for pixels [first, first+count) of a line starting at byte address base.
    task automatic push_writes(input logic [AWIDTH-1:0] base, input int first, input int count,
                               input int width, input logic bank);
        wr_t w;
        for (int i = first; i < first + count; i++) begin
            w.idx  = XBITS'(i);
            w.data = base + 32'(4 * i);
            w.bank = bank;
            w.done = (i == width - 1);
            exp_wr.push_back(w);
        end
    endtask

    // Monitor: compares every handshake and write against the queues.
    initial begin
        burst_t b;
        wr_t    w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_rd_valid && i_rd_ready) begin
                    check("burst_expected", 64'(exp_burst.size() != 0), 64'd1);
                    if (exp_burst.size() != 0) begin
                        b = exp_burst.pop_front();
                        check("burst_addr", o_rd_addr, b.addr);
                        check("burst_len", o_rd_len, b.len);
                    end
                end
                if (o_lb_we) begin
                    check("write_expected", 64'(exp_wr.size() != 0), 64'd1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("lb_addr", o_lb_addr, w.idx);
                        check("lb_wdata", o_lb_wdata, w.data);
                        check("lb_bank", o_lb_bank, w.bank);
                        check("line_done", o_line_done, w.done);
                    end
                end else if (o_line_done) begin
                    check("stray_line_done", o_line_done, 1'b0);
                end
            end
        end
    end

    // Memory responder: after each accepted address, return len+1 back-to-back beats.
    initial begin
        logic [AWIDTH-1:0] a;
        int                n;
        forever begin
            @(negedge clk);
            if (rst_n && o_rd_valid && i_rd_ready) begin
                a = o_rd_addr;
                n = int'(o_rd_len) + 1;
                @(posedge clk); #1;
                for (int k = 0; k < n; k++) begin
                    i_rdata_valid = 1'b1;
                    i_rdata       = a + 32'(4 * k);
                    @(posedge clk); #1;
                end
                i_rdata_valid = 1'b0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic frame(input logic en, input logic [AWIDTH-1:0] base, input logic [15:0] stride,
                         input int width, input int height);
        @(posedge clk); #1;
        i_enable      = en;
        i_base        = base;
        i_stride      = stride;
        i_width       = XBITS'(width);
        i_height      = XBITS'(height);
        i_frame_start = 1'b1;
        @(posedge clk); #1;
        i_frame_start = 1'b0;
    endtask

    task automatic line_req();
        @(posedge clk); #1;
        i_line_req = 1'b1;
        @(posedge clk); #1;
        i_line_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((o_busy || exp_wr.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, o_busy, 1'b0);
    endtask

    task automatic expect_quiet(input string name);
        repeat (5) begin
            @(negedge clk);
            check({name, "_rd_valid"}, o_rd_valid, 1'b0);
            check({name, "_busy"}, o_busy, 1'b0);
        end
    endtask

    initial begin
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_valid", o_rd_valid, 1'b0);
        check("rst_rd_addr", o_rd_addr, 32'h0);
        check("rst_rd_len", o_rd_len, 4'h0);
        check("rst_lb_we", o_lb_we, 1'b0);
        check("rst_lb_addr", o_lb_addr, 11'h0);
        check("rst_lb_wdata", o_lb_wdata, 32'h0);
        check("rst_lb_bank", o_lb_bank, 1'b0);
        check("rst_line_done", o_line_done, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_overrun", o_overrun_cnt, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Not armed out of reset: a request is ignored
        line_req();
        expect_quiet("unarmed");

        // Basic line: 40 pixels -> bursts of 16, 16, 8
        i_rd_ready = 1'b1;
        frame(1'b1, 32'h1000_0000, 16'h0100, 40, 4);
        push_burst(32'h1000_0000, 15);
        push_burst(32'h1000_0040, 15);
        push_burst(32'h1000_0080, 7);
        push_writes(32'h1000_0000, 0, 40, 40, 1'b0);
        line_req();
        @(negedge clk);
        check("req_to_rd_valid", o_rd_valid, 1'b1);
        check("req_to_busy", o_busy, 1'b1);
        wait_idle("basic");
        repeat (2) @(negedge clk);
        check("bank_after_line0", o_lb_bank, 1'b1);

        // Backpressure on the first burst of line 1 (base + stride)
        push_burst(32'h1000_0100, 15);
        push_burst(32'h1000_0140, 15);
        push_burst(32'h1000_0180, 7);
        push_writes(32'h1000_0100, 0, 40, 40, 1'b1);
        @(posedge clk); #1;
        i_rd_ready = 1'b0;
        i_line_req = 1'b1;
        @(posedge clk); #1;
        i_line_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_rd_valid", o_rd_valid, 1'b1);
            check("bp_rd_addr", o_rd_addr, 32'h1000_0100);
            check("bp_rd_len", o_rd_len, 4'd15);
        end
        @(posedge clk); #1;
        i_rd_ready = 1'b1;
        wait_idle("backpressure");
        repeat (2) @(negedge clk);
        check("bank_after_line1", o_lb_bank, 1'b0);

        // Overrun: a second request during DATA is dropped and counted
        push_burst(32'h1000_0200, 15);
        push_burst(32'h1000_0240, 15);
        push_burst(32'h1000_0280, 7);
        push_writes(32'h1000_0200, 0, 40, 40, 1'b0);
        line_req();
        n = 0;
        while (!o_lb_we && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("overrun_reach_data", o_lb_we, 1'b1);
        line_req();
        wait_idle("overrun");
        check("overrun_cnt_1", o_overrun_cnt, 16'd1);

        // Frame limit and stride: two lines, third request ignored and not counted
        frame(1'b1, 32'h2000_0000, 16'h1000, 8, 2);
        push_burst(32'h2000_0000, 7);
        push_writes(32'h2000_0000, 0, 8, 8, 1'b0);
        line_req();
        wait_idle("limit_line0");
        push_burst(32'h2000_1000, 7);
        push_writes(32'h2000_1000, 0, 8, 8, 1'b1);
        line_req();
        wait_idle("limit_line1");
        line_req();
        expect_quiet("limit_line2");
        check("limit_overrun", o_overrun_cnt, 16'd1);

        // Frame start mid-burst: 5 beats written, remaining 11 drained silently
        frame(1'b1, 32'h3000_0000, 16'h0040, 16, 4);
        push_burst(32'h3000_0000, 15);
        push_writes(32'h3000_0000, 0, 16, 16, 1'b0);
        line_req();
        wait_idle("mid_line0");
        push_burst(32'h3000_0040, 15);
        push_writes(32'h3000_0040, 0, 5, 16, 1'b1);
        line_req();
        n = 0;
        @(negedge clk);
        while (!(o_rd_valid && i_rd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_handshake_seen", o_rd_valid, 1'b1);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        i_base        = 32'h4000_0000;
        i_width       = XBITS'(16);
        i_frame_start = 1'b1;
        @(posedge clk); #1;
        i_frame_start = 1'b0;
        wait_idle("mid_drain");
        repeat (20) @(negedge clk);
        check("mid_writes_consumed", 64'(exp_wr.size()), 64'd0);
        push_burst(32'h4000_0000, 15);
        push_writes(32'h4000_0000, 0, 16, 16, 1'b0);
        line_req();
        wait_idle("mid_newbase");

        // Degenerate configs: zero width, then disabled at frame start
        frame(1'b1, 32'h4800_0000, 16'h0040, 0, 4);
        line_req();
        expect_quiet("width0");
        frame(1'b0, 32'h4800_0000, 16'h0040, 16, 4);
        line_req();
        expect_quiet("disabled");
        check("degenerate_overrun", o_overrun_cnt, 16'd1);

        // Saturation: 70000 dropped requests while the address is held off
        frame(1'b1, 32'h5000_0000, 16'h0040, 16, 4);
        push_burst(32'h5000_0000, 15);
        push_writes(32'h5000_0000, 0, 16, 16, 1'b0);
        @(posedge clk); #1;
        i_rd_ready = 1'b0;
        i_line_req = 1'b1;
        repeat (70001) @(posedge clk);
        #1;
        i_line_req = 1'b0;
        @(negedge clk);
        check("sat_overrun", o_overrun_cnt, 16'hFFFF);
        @(posedge clk); #1;
        i_rd_ready = 1'b1;
        wait_idle("sat_line");
        check("sat_overrun_hold", o_overrun_cnt, 16'hFFFF);

        repeat (5) @(negedge clk);
        check("bursts_all_seen", 64'(exp_burst.size()), 64'd0);
        check("writes_all_seen", 64'(exp_wr.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
